uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive end of the UART link whose transmit side runs off the baud-rate divider.
- Oversamples the asynchronous `rx_serial` line on the system clock, detects the start bit, and samples each bit at mid-point. The baud timing comes from an internal counter clock-enable, not a derived clock.
- Delivers bytes over a valid/ready handshake, with framing and overrun reporting.

Parameters:
- CLKS_PER_BIT, 21, system clocks per serial bit. Matches the 21-cycle divider period. Minimum 4.
- DATA_BITS, 8, data bits per frame, LSB first. Range 5..8.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_serial  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data on a clock edge where rx_valid && rx_ready.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a new byte was dropped because the previous byte was unconsumed.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is synchronous, active-high, on clock_in.
  - Reset values: rx_data=0, rx_valid=0, framing_error=0, overrun=0, busy=0.
  - FSM goes to IDLE, bit counter=0, baud counter=0.
  - Both synchronizer flops reset to 1 (idle line).
  - Reset mid-frame abandons the frame with no error pulses.
- Input path:
  - 2-flop synchronizer; FSM uses the second stage (rx_s).
  - Latency from pin to rx_s: 2 cycles.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state entry; otherwise increments each cycle.
- IDLE:
  - rx_s==0 -> START.
- START:
  - At cnt==(CLKS_PER_BIT-1)/2, i.e. 10 for the default: if rx_s==0 -> DATA. If rx_s==1, treat it as a glitch -> IDLE with no error.
- DATA:
  - At cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of a DATA_BITS shift register (LSB first) and increment bitcnt.
  - After DATA_BITS samples -> STOP.
- STOP, at cnt==CLKS_PER_BIT-1:
  - rx_s==1: frame good -> deliver, then IDLE. Returning to IDLE mid-stop-bit is intentional; it allows back-to-back frames.
  - rx_s==0: framing_error pulses on the next cycle and the byte is discarded -> WAIT_HIGH.
- WAIT_HIGH:
  - Stays until rx_s==1 -> IDLE. This prevents a break condition from retriggering START.
- Delivery (registered, one cycle after the stop sample):
  - rx_valid==0, or rx_ready==1 that same cycle: load rx_data and set rx_valid=1. No overrun.
  - rx_valid==1 and rx_ready==0: keep the old rx_data, pulse overrun, rx_valid stays 1.
- Handshake:
  - rx_valid falls on the edge where rx_valid && rx_ready, unless a new byte loads on that same edge; in that case rx_valid stays 1.
  - rx_ready while rx_valid==0 is ignored.
  - rx_data is stable while rx_valid==1.
- End-to-end latency:
  - Pin falling edge to rx_valid rising is 3 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles (±1).
  - For defaults this is 203±1 cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled at cnt==CLKS_PER_BIT-1.
  - Adds parameter PARITY_ODD, default 0 (0 = even parity, 1 = odd parity).
  - Adds output port parity_error, 1 bit, reset 0.
  - On mismatch, the frame still completes STOP. The byte is discarded (no rx_valid, no overrun) and parity_error pulses one cycle, coincident with where rx_valid would have risen.
  - A framing error takes priority: only framing_error pulses.
- When undefined:
  - No PARITY state, no parity_error port; the frame is 1+DATA_BITS+1 bits.

Test Plan:
- Reset, then hold rx_serial=1 for 500 cycles -> rx_valid=0, busy=0, no error pulses.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with rx_ready=1 -> rx_data=0xA5, rx_valid high for exactly 1 cycle, 203±1 cycles after the start edge.
- 5-cycle low glitch on rx_serial -> FSM returns to IDLE, rx_valid stays 0, framing_error stays 0.
- Send 0x3C with the stop bit forced low, then hold the line low 100 cycles, then release -> framing_error single pulse, no rx_valid, no new START until the line goes high.
- rx_ready=0; send 0x11 then back-to-back 0x22 -> rx_data=0x11 held, overrun pulses once; then rx_ready=1 -> 0x11 consumed, rx_valid=0.
- With UART_RX_PARITY_EN and PARITY_ODD=0:
  - Send 0x07 with parity bit 1 -> rx_data=0x07, rx_valid=1.
  - Resend 0x07 with parity bit 0 -> parity_error pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synced line, mid-bit sampling, byte out ~3+MID+(DATA_BITS+1)*CLKS_PER_BIT+1 cycles after start edge.
// Backpressure: an unconsumed byte is kept and the new one dropped with an overrun pulse. UART_RX_PARITY_EN adds a parity bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 21,
    parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 clock_in,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd3;
`endif

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clock_in) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bitcnt        <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            rx_meta       <= rx_serial;
            rx_s          <= rx_meta;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            cnt <= cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was noise; drop silently.
                    if (cnt == MID) begin
                        cnt    <= '0;
                        bitcnt <= '0;
                        state  <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + BW'(1);
                        if (bitcnt == BLAST)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop-bit lets a following start edge be caught immediately.
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad)
                                parity_error <= 1'b1;
                            else
`endif
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun  <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, good frame + latency, glitch, framing error, overrun, optional parity.
module tb_uart_rx;

    localparam int CPB = 21;
`ifdef UART_RX_PARITY_EN
    localparam int NB      = 11;
    localparam int LAT_EXP = 224;
`else
    localparam int NB      = 10;
    localparam int LAT_EXP = 203;
`endif

    logic       clock_in  = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    int         perr_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int valid_rises = 0;
    int valid_hi    = 0;
    int fe_cnt      = 0;
    int ovr_cnt     = 0;
    int last_rise   = 0;
    int t_start     = 0;
    int base;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clock_in      (clock_in),
        .rst           (rst),
        .rx_serial     (rx_serial),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error  (parity_error),
`endif
        .busy          (busy)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    always @(negedge clock_in) begin
        if (rx_valid) valid_hi++;
        if (rx_valid && !prev_valid) begin
            valid_rises++;
            last_data = rx_data;
            last_rise = cyc;
        end
        prev_valid = rx_valid;
        if (framing_error) fe_cnt++;
        if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) perr_cnt++;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    // par < 0 sends the correct even-parity bit; otherwise par[0] is forced.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int par);
        logic [9:0] fr;
        logic       pbit;
        pbit = (par < 0) ? ^d : par[0];
        fr   = {pbit, d, 1'b0};
        t_start = cyc;
        for (int i = 0; i < NB; i++) begin
            rx_serial = (i == NB - 1) ? stop : fr[i];
            wait_cyc(CPB);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wait_cyc(3);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'h00);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_fe", 32'(framing_error), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;

        wait_cyc(500);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid_rises", 32'(valid_rises), 32'd0);
        check_eq("idle_fe", 32'(fe_cnt), 32'd0);

        // Good frame, consumer always ready
        rx_ready = 1'b1;
        valid_hi = 0;
        send_byte(8'hA5, 1'b1, -1);
        wait_cyc(30);
        check_eq("a5_rises", 32'(valid_rises), 32'd1);
        check_eq("a5_data", 32'(last_data), 32'hA5);
        check_eq("a5_valid_width", 32'(valid_hi), 32'd1);
        check_eq("a5_latency_ok", 32'((last_rise - t_start >= LAT_EXP - 1) && (last_rise - t_start <= LAT_EXP + 1)), 32'd1);
        check_eq("a5_busy_after", 32'(busy), 32'd0);

        // Short low glitch
        rx_serial = 1'b0;
        wait_cyc(5);
        rx_serial = 1'b1;
        wait_cyc(3);
        check_eq("glitch_busy_mid", 32'(busy), 32'd1);
        wait_cyc(40);
        check_eq("glitch_busy_end", 32'(busy), 32'd0);
        check_eq("glitch_rises", 32'(valid_rises), 32'd1);
        check_eq("glitch_fe", 32'(fe_cnt), 32'd0);

        // Stop bit low, then break held low
        send_byte(8'h3C, 1'b0, -1);
        wait_cyc(100);
        check_eq("fe_busy_break", 32'(busy), 32'd1);
        check_eq("fe_pulse_during", 32'(fe_cnt), 32'd1);
        rx_serial = 1'b1;
        wait_cyc(300);
        check_eq("fe_pulse_total", 32'(fe_cnt), 32'd1);
        check_eq("fe_rises", 32'(valid_rises), 32'd1);
        check_eq("fe_busy_end", 32'(busy), 32'd0);

        // Overrun: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b1, -1);
        wait_cyc(30);
        check_eq("ovr_valid", 32'(rx_valid), 32'd1);
        check_eq("ovr_data_held", 32'(rx_data), 32'h11);
        check_eq("ovr_pulses", 32'(ovr_cnt), 32'd1);
        check_eq("ovr_rises", 32'(valid_rises), 32'd2);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        wait_cyc(2);
        check_eq("ovr_consumed", 32'(rx_valid), 32'd0);
        check_eq("ovr_data_after", 32'(rx_data), 32'h11);
        check_eq("ovr_no_more", 32'(ovr_cnt), 32'd1);

`ifdef UART_RX_PARITY_EN
        rx_ready = 1'b1;
        base = valid_rises;
        send_byte(8'h07, 1'b1, 1);
        wait_cyc(30);
        check_eq("par_ok_rises", 32'(valid_rises), 32'(base + 1));
        check_eq("par_ok_data", 32'(last_data), 32'h07);
        check_eq("par_ok_perr", 32'(perr_cnt), 32'd0);
        base = valid_rises;
        send_byte(8'h07, 1'b1, 0);
        wait_cyc(30);
        check_eq("par_bad_perr", 32'(perr_cnt), 32'd1);
        check_eq("par_bad_rises", 32'(valid_rises), 32'(base));
        check_eq("par_bad_ovr", 32'(ovr_cnt), 32'd1);
`else
        base = valid_rises;
        rx_ready = 1'b1;
        send_byte(8'h5A, 1'b1, -1);
        wait_cyc(30);
        check_eq("5a_rises", 32'(valid_rises), 32'(base + 1));
        check_eq("5a_data", 32'(last_data), 32'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
